conv_seq_ctrl: RTL and testbench

Sequencer for the 3x3 convolution engine. It accepts a valid/ready stream of 24-bit operand words and steers each word into one of the engine's six 24-bit operand registers: kernel registers 3-5 and pixel registers 0-2. It pulses the engine's accumulator clear/enable controls, runs 1..N accumulation passes per job (multi-channel), and returns the final 32-bit accumulated sum on a valid/ready result port.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_seq_perf.sv | 32 +++
 rtl/conv_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_conv_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD_K = 3'd2,
    LOAD_P = 3'd3,
    MAC    = 3'd4,
    OUT    = 3'd5
  } state_t;

  localparam logic [2:0] SEL_PIX_BASE      = 3'd0;
  localparam logic [2:0] SEL_KER_BASE      = 3'd3;
  localparam int         WORDS_PER_OPERAND = 3;

  typedef logic [23:0] operand_t;
  typedef logic [31:0] result_t;

endpackage

// File: rtl/conv_seq_perf.sv
// Saturating busy/stall cycle counter pair for the convolution sequencer.
// Only instantiated when CONV_SEQ_CTRL_PERF_EN is defined.
module conv_seq_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        busy,
  input  logic        stall,
  output logic [31:0] busy_cycles,
  output logic [31:0] stall_cycles
);

  logic [1:0] inc;
  assign inc = {stall, busy};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          cnt_reg <= '0;
        end else if (inc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
    end
  endgenerate

  assign busy_cycles  = g_cnt[0].cnt_reg;
  assign stall_cycles = g_cnt[1].cnt_reg;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Operand sequencer for the 3x3 convolution engine: steers the word stream into
// engine registers, runs 1..N accumulation passes, returns the sum. Optional
// performance counters are enabled with CONV_SEQ_CTRL_PERF_EN.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CH_W-1:0] cfg_channels,
  input  logic            cfg_kernel_mode,
  output logic            busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  operand_t        in_data,
  output logic            eng_we,
  output logic [2:0]      eng_sel,
  output operand_t        eng_data,
  output logic            eng_acc_clear,
  output logic            eng_acc_enable,
  input  result_t         eng_result,
  output logic            res_valid,
  input  logic            res_ready,
  output result_t         res_data
`ifdef CONV_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_busy_cycles,
  output logic [31:0]     perf_stall_cycles
`endif
);

  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_OPERAND - 1);

  state_t          state_reg, state_next;
  logic [CH_W-1:0] pass_reg, pass_next;
  logic [CH_W-1:0] channels_reg, channels_next;
  logic            mode_reg, mode_next;
  logic [1:0]      word_idx_reg, word_idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pass_reg     <= '0;
      channels_reg <= '0;
      mode_reg     <= 1'b0;
      word_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pass_reg     <= pass_next;
      channels_reg <= channels_next;
      mode_reg     <= mode_next;
      word_idx_reg <= word_idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pass_next      = pass_reg;
    channels_next  = channels_reg;
    mode_next      = mode_reg;
    word_idx_next  = word_idx_reg;
    in_ready       = 1'b0;
    eng_we         = 1'b0;
    eng_sel        = 3'd0;
    eng_data       = '0;
    eng_acc_clear  = 1'b0;
    eng_acc_enable = 1'b0;
    res_valid      = 1'b0;
    res_data       = '0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          channels_next = (cfg_channels == '0) ? CH_W'(1) : cfg_channels;
          mode_next     = cfg_kernel_mode;
          pass_next     = '0;
          word_idx_next = '0;
          state_next    = CLEAR;
        end
      end
      CLEAR: begin
        eng_acc_clear = 1'b1;
        state_next    = mode_reg ? LOAD_K : LOAD_P;
      end
      LOAD_K, LOAD_P: begin
        in_ready = 1'b1;
        eng_we   = in_valid;
        eng_data = in_data;
        eng_sel  = ((state_reg == LOAD_K) ? SEL_KER_BASE : SEL_PIX_BASE) + {1'b0, word_idx_reg};
        if (in_valid) begin
          if (word_idx_reg == LAST_WORD) begin
            word_idx_next = '0;
            state_next    = (state_reg == LOAD_K) ? LOAD_P : MAC;
          end else begin
            word_idx_next = word_idx_reg + 2'd1;
          end
        end
      end
      MAC: begin
        eng_acc_enable = 1'b1;
        if (pass_reg == channels_reg - CH_W'(1)) begin
          state_next = OUT;
        end else begin
          pass_next  = pass_reg + CH_W'(1);
          state_next = mode_reg ? LOAD_K : LOAD_P;
        end
      end
      OUT: begin
        // Clear/enable are low here, so eng_result cannot move under res_data.
        res_valid = 1'b1;
        res_data  = eng_result;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

`ifdef CONV_SEQ_CTRL_PERF_EN
  conv_seq_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .clear        ((state_reg == IDLE) && start),
    .busy         (busy),
    .stall        (in_ready && !in_valid),
    .busy_cycles  (perf_busy_cycles),
    .stall_cycles (perf_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl with a behavioural 3x3 engine model.
module tb_conv_seq_ctrl;
  import conv_pkg::*;

  localparam int CH_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CH_W-1:0] cfg_channels;
  logic            cfg_kernel_mode;
  logic            busy;
  logic            in_valid;
  logic            in_ready;
  logic [23:0]     in_data;
  logic            eng_we;
  logic [2:0]      eng_sel;
  logic [23:0]     eng_data;
  logic            eng_acc_clear;
  logic            eng_acc_enable;
  logic [31:0]     eng_result;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_data;
`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [31:0]     perf_busy_cycles;
  logic [31:0]     perf_stall_cycles;
`endif

  conv_seq_ctrl #(.CH_W(CH_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_channels    (cfg_channels),
    .cfg_kernel_mode (cfg_kernel_mode),
    .busy            (busy),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .eng_we          (eng_we),
    .eng_sel         (eng_sel),
    .eng_data        (eng_data),
    .eng_acc_clear   (eng_acc_clear),
    .eng_acc_enable  (eng_acc_enable),
    .eng_result      (eng_result),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data)
`ifdef CONV_SEQ_CTRL_PERF_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Signed dot product of one pixel word with one kernel word (3 bytes, MSB = element 0).
  function automatic logic [31:0] dot3(input logic [23:0] p, input logic [23:0] k);
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic [31:0]       s;
    s = '0;
    for (int j = 0; j < 3; j++) begin
      a = p[23-8*j -: 8];
      b = k[23-8*j -: 8];
      s = s + 32'(int'(a) * int'(b));
    end
    return s;
  endfunction

  // Engine model: six operand registers plus a wrapping 32-bit accumulator.
  logic [23:0] eng_regs [6];
  logic [31:0] acc;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) eng_regs[i] <= '0;
      acc <= '0;
    end else begin
      if (eng_we && (eng_sel < 3'd6)) eng_regs[eng_sel] <= eng_data;
      if (eng_acc_clear)
        acc <= '0;
      else if (eng_acc_enable)
        acc <= acc + dot3(eng_regs[0], eng_regs[3]) + dot3(eng_regs[1], eng_regs[4])
                   + dot3(eng_regs[2], eng_regs[5]);
    end
  end
  assign eng_result = acc;

  int n_clear, n_mac, n_viol;
  always @(negedge clk) begin
    if (eng_acc_clear) n_clear++;
    if (eng_acc_enable) n_mac++;
    if (eng_acc_clear && eng_acc_enable) n_viol++;
    if (eng_we && !in_ready) n_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Stimulus words per pass and the kernel the engine currently holds.
  logic [23:0] kwords [16][3];
  logic [23:0] pwords [16][3];
  logic [23:0] kref [3];
  logic [23:0] wq_data [$];
  logic [2:0]  wq_sel  [$];

  task automatic fill_all(input logic [23:0] k, input logic [23:0] p);
    for (int q = 0; q < 16; q++)
      for (int i = 0; i < 3; i++) begin
        kwords[q][i] = k;
        pwords[q][i] = p;
      end
  endtask

  task automatic run_job(input string name, input bit mode, input int ch_cfg, input bit toggle,
                         input int hold, input bit poke_start);
    int          ch, s0, guard, stalls, exp_lat, h;
    logic [31:0] exp_sum;
    ch      = (ch_cfg == 0) ? 1 : ch_cfg;
    exp_sum = '0;
    wq_data.delete();
    wq_sel.delete();
    for (int q = 0; q < ch; q++) begin
      if (mode) begin
        for (int i = 0; i < 3; i++) begin
          kref[i] = kwords[q][i];
          wq_data.push_back(kwords[q][i]);
          wq_sel.push_back(3'(3 + i));
        end
      end
      for (int i = 0; i < 3; i++) begin
        exp_sum = exp_sum + dot3(pwords[q][i], kref[i]);
        wq_data.push_back(pwords[q][i]);
        wq_sel.push_back(3'(i));
      end
    end

    @(negedge clk);
    n_clear = 0; n_mac = 0; n_viol = 0;
    start = 1'b1;
    cfg_channels = CH_W'(ch_cfg);
    cfg_kernel_mode = mode;
    s0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);

    guard = 0;
    stalls = 0;
    while (wq_data.size() > 0 && guard < 2000) begin
      start    = (poke_start && guard == 3) ? 1'b1 : 1'b0;
      in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = wq_data[0];
      #1;
      if (in_ready && !in_valid) stalls++;
      if (in_ready && in_valid) begin
        check({name, "_we"}, 32'(eng_we), 32'd1);
        check({name, "_sel"}, 32'(eng_sel), 32'(wq_sel[0]));
        check({name, "_wdata"}, 32'(eng_data), 32'(wq_data[0]));
        void'(wq_data.pop_front());
        void'(wq_sel.pop_front());
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (guard >= 2000) check({name, "_word_timeout"}, 32'(wq_data.size()), 32'd0);

    guard = 0;
    while (res_valid !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_res_valid"}, 32'(res_valid), 32'd1);
    if (!toggle) begin
      exp_lat = 2 + ch * ((mode ? 6 : 3) + 1);
      check({name, "_latency"}, 32'(cyc - s0), 32'(exp_lat));
    end
    check({name, "_res_data"}, res_data, exp_sum);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(res_valid), 32'd1);
      check({name, "_hold_data"}, res_data, exp_sum);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    h = cyc;
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_idle_res_valid"}, 32'(res_valid), 32'd0);
    check({name, "_clear_pulses"}, 32'(n_clear), 32'd1);
    check({name, "_mac_pulses"}, 32'(n_mac), 32'(ch));
    check({name, "_violations"}, 32'(n_viol), 32'd0);
`ifdef CONV_SEQ_CTRL_PERF_EN
    check({name, "_perf_busy"}, perf_busy_cycles, 32'(h - 1 - s0));
    check({name, "_perf_stall"}, perf_stall_cycles, 32'(stalls));
`endif
    $display("[TB] job %s mode=%0d ch=%0d result=0x%08h expected=0x%08h", name, mode, ch,
             res_data, exp_sum);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check({name, "_eng_we"}, 32'(eng_we), 32'd0);
    check({name, "_eng_sel"}, 32'(eng_sel), 32'd0);
    check({name, "_eng_ctrl"}, 32'({eng_acc_clear, eng_acc_enable}), 32'd0);
    check({name, "_res_valid"}, 32'(res_valid), 32'd0);
    check({name, "_res_data"}, res_data, 32'd0);
  endtask

  initial begin
    int accepted, guard;
    rst = 1'b1; start = 1'b0; cfg_channels = '0; cfg_kernel_mode = 1'b0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    for (int i = 0; i < 3; i++) kref[i] = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Directed jobs; the order leaves kernel bytes = 2 resident for the mode-0 job.
    fill_all(24'h7F7F7F, 24'hFFFFFF);
    run_job("neg", 1'b1, 1, 1'b0, 0, 1'b0);
    fill_all(24'h010101, 24'h010101);
    run_job("three_ch", 1'b1, 3, 1'b0, 0, 1'b0);
    fill_all(24'h020202, 24'h010101);
    run_job("basic", 1'b1, 1, 1'b0, 0, 1'b0);
    fill_all(24'h000000, 24'h030303);
    run_job("resident", 1'b0, 2, 1'b0, 0, 1'b0);
    fill_all(24'h020202, 24'h010101);
    run_job("backpressure", 1'b1, 1, 1'b1, 5, 1'b1);
    run_job("zero_ch", 1'b1, 0, 1'b0, 1, 1'b0);

    // Reset after four accepted words abandons the job.
    @(negedge clk);
    start = 1'b1; cfg_channels = CH_W'(1); cfg_kernel_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    accepted = 0; guard = 0;
    while (accepted < 4 && guard < 100) begin
      in_valid = 1'b1;
      in_data = 24'h050505;
      #1;
      if (in_ready) accepted++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("midrst_words", 32'(accepted), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) kref[i] = '0;
    fill_all(24'h020202, 24'h010101);
    run_job("after_rst", 1'b1, 1, 1'b0, 0, 1'b0);

    // Randomized jobs against the reference sum.
    for (int r = 0; r < 8; r++) begin
      for (int q = 0; q < 16; q++)
        for (int i = 0; i < 3; i++) begin
          kwords[q][i] = 24'($urandom);
          pwords[q][i] = 24'($urandom);
        end
      run_job($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
